// File: rtl/intc_apb_fabric_if.sv
// Bus bundle for intc_apb_fabric: upstream APB slave port plus SLV_NUM-way downstream APB master port.
// The slave modport is the fabric's view; the master modport is the bridge/controllers' view.
interface intc_apb_fabric_if #(
    parameter int unsigned SLV_NUM = 2
);
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [31:0]               paddr;
    logic [3:0]                pstrb;
    logic [31:0]               pwdata;
    logic [31:0]               prdata;
    logic                      pslverr;
    logic                      pready;

    logic [SLV_NUM-1:0]        s_psel;
    logic                      s_penable;
    logic                      s_pwrite;
    logic [31:0]               s_paddr;
    logic [3:0]                s_pstrb;
    logic [31:0]               s_pwdata;
    logic [SLV_NUM*32-1:0]     s_prdata;
    logic [SLV_NUM-1:0]        s_pslverr;
    logic [SLV_NUM-1:0]        s_pready;

    modport slave (
        input  psel, penable, pwrite, paddr, pstrb, pwdata,
        output prdata, pslverr, pready,
        output s_psel, s_penable, s_pwrite, s_paddr, s_pstrb, s_pwdata,
        input  s_prdata, s_pslverr, s_pready
    );

    modport master (
        output psel, penable, pwrite, paddr, pstrb, pwdata,
        input  prdata, pslverr, pready,
        input  s_psel, s_penable, s_pwrite, s_paddr, s_pstrb, s_pwdata,
        output s_prdata, s_pslverr, s_pready
    );
endinterface

// File: rtl/intc_apb_fabric.sv
// Registered APB fan-out to SLV_NUM interrupt-controller slaves, selected by paddr[SEL_LSB +: SEL_W].
// Define INTC_APB_TIMEOUT_EN to abort DACCESS with PSLVERR after TIMEOUT cycles without s_pready.
module intc_apb_fabric #(
    parameter int unsigned SLV_NUM = 2,
    parameter int unsigned SEL_LSB = 26,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    intc_apb_fabric_if.slave    bus
);
    localparam int unsigned SEL_W = (SLV_NUM > 1) ? $clog2(SLV_NUM) : 1;
    localparam logic [SEL_W:0] SLV_LIMIT = (SEL_W+1)'(SLV_NUM);
`ifdef INTC_APB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
`else
    localparam int unsigned unused_timeout = TIMEOUT;
`endif

    typedef enum logic [3:0] {
        S_IDLE    = 4'b0001,
        S_DSETUP  = 4'b0010,
        S_DACCESS = 4'b0100,
        S_RESP    = 4'b1000
    } state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [31:0]        addr_q, addr_d;
    logic               write_q, write_d;
    logic [3:0]         strb_q, strb_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [SLV_NUM-1:0] psel_q, psel_d;
    logic               penable_q, penable_d;
    logic               pready_q, pready_d;
    logic               pslverr_q, pslverr_d;
    logic [31:0]        prdata_q, prdata_d;
`ifdef INTC_APB_TIMEOUT_EN
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

    logic [SEL_W-1:0]   sel_in;
    logic [SLV_NUM-1:0] sel_oh;
    logic               sel_mapped;
    logic [31:0]        rsp_rdata;
    logic               rsp_err;
    logic               rsp_rdy;

    // Decode of the incoming select field and mux of the addressed slave's response.
    always_comb begin
        sel_in     = bus.paddr[SEL_LSB +: SEL_W];
        sel_mapped = ({1'b0, sel_in} < SLV_LIMIT);
        sel_oh     = '0;
        rsp_rdata  = '0;
        rsp_err    = 1'b0;
        rsp_rdy    = 1'b0;
        for (int unsigned i = 0; i < SLV_NUM; i++) begin
            sel_oh[i] = (sel_in == SEL_W'(i));
            if (sel_q == SEL_W'(i)) begin
                rsp_rdata = bus.s_prdata[32*i +: 32];
                rsp_err   = bus.s_pslverr[i];
                rsp_rdy   = bus.s_pready[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        write_d   = write_q;
        strb_d    = strb_q;
        wdata_d   = wdata_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        prdata_d  = prdata_q;
`ifdef INTC_APB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.psel && !bus.penable) begin
                    sel_d   = sel_in;
                    addr_d  = bus.paddr;
                    write_d = bus.pwrite;
                    strb_d  = bus.pstrb;
                    wdata_d = bus.pwdata;
                    if (sel_mapped) begin
                        state_d = S_DSETUP;
                        psel_d  = sel_oh;
`ifdef INTC_APB_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        // Unmapped window: answer locally instead of hanging the bus.
                        state_d   = S_RESP;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                        prdata_d  = '0;
                    end
                end
            end
            S_DSETUP: begin
                state_d   = S_DACCESS;
                penable_d = 1'b1;
            end
            S_DACCESS: begin
`ifdef INTC_APB_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
`endif
                if (rsp_rdy) begin
                    state_d   = S_RESP;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    pready_d  = 1'b1;
                    pslverr_d = rsp_err;
                    prdata_d  = write_q ? 32'd0 : rsp_rdata;
                end
`ifdef INTC_APB_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d   = S_RESP;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                    prdata_d  = '0;
                end
`endif
            end
            S_RESP: begin
                state_d   = S_IDLE;
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = '0;
            end
            default: begin
                state_d   = S_IDLE;
                psel_d    = '0;
                penable_d = 1'b0;
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sel_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            strb_q    <= '0;
            wdata_q   <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
`ifdef INTC_APB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            strb_q    <= strb_d;
            wdata_q   <= wdata_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
`ifdef INTC_APB_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign bus.prdata    = prdata_q;
    assign bus.pslverr   = pslverr_q;
    assign bus.pready    = pready_q;
    assign bus.s_psel    = psel_q;
    assign bus.s_penable = penable_q;
    assign bus.s_pwrite  = write_q;
    assign bus.s_paddr   = addr_q;
    assign bus.s_pstrb   = strb_q;
    assign bus.s_pwdata  = wdata_q;
endmodule

// File: tb/tb_intc_apb_fabric.sv
// Scoreboard bench for intc_apb_fabric: three slaves, one unmapped select value, TIMEOUT=4.
module tb_intc_apb_fabric;
    localparam int unsigned SLV_NUM = 3;
    localparam int unsigned SEL_LSB = 26;
    localparam int unsigned TIMEOUT = 4;
`ifdef INTC_APB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] prdata;
        logic        pslverr;
        int          lat;
        int          start;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    intc_apb_fabric_if #(.SLV_NUM(SLV_NUM)) bus();

    intc_apb_fabric #(.SLV_NUM(SLV_NUM), .SEL_LSB(SEL_LSB), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t         sb[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    int           cur_wait = 0;
    logic [2:0]   noise = 3'b000;
    logic [7:0]   acc_cnt;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) noise <= 3'($urandom);

    // Slave model: addressed slave becomes ready after cur_wait ACCESS cycles; others toggle randomly.
    always @(posedge clk or posedge rst) begin
        if (rst) acc_cnt <= 8'd0;
        else if (bus.s_penable && (bus.s_psel != '0)) acc_cnt <= acc_cnt + 8'd1;
        else acc_cnt <= 8'd0;
    end
    assign bus.s_pready = ({SLV_NUM{bus.s_penable && (acc_cnt == 8'(cur_wait))}} & bus.s_psel)
                        | (noise & ~bus.s_psel);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [31:0] addr, input logic write, input logic [31:0] wdata,
                                   input logic [3:0] strb, input int wt,
                                   input logic [95:0] rdv, input logic [2:0] errv);
        exp_t e;
        int   sel;
        e.addr = addr; e.write = write; e.wdata = wdata; e.strb = strb; e.start = 0;
        sel = int'(addr[SEL_LSB +: 2]);
        if (sel >= int'(SLV_NUM)) begin
            e.prdata = 32'd0; e.pslverr = 1'b1; e.lat = 1;
        end else if (TO_EN && wt >= int'(TIMEOUT)) begin
            e.prdata = 32'd0; e.pslverr = 1'b1; e.lat = int'(TIMEOUT) + 2;
        end else begin
            e.prdata  = write ? 32'd0 : rdv[32*sel +: 32];
            e.pslverr = errv[sel];
            e.lat     = 3 + wt;
        end
        return e;
    endfunction

    // Monitor: checks downstream phase fields and pops the scoreboard on each upstream completion.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.s_psel != '0) begin
                if (sb.size() == 0) check("downstream_without_xfer", 64'(bus.s_psel), 64'd0);
                else begin
                    e = sb[0];
                    check("s_psel", 64'(bus.s_psel), 64'(3'b001 << e.addr[SEL_LSB +: 2]));
                    check("s_paddr", 64'(bus.s_paddr), 64'(e.addr));
                    check("s_pwrite", 64'(bus.s_pwrite), 64'(e.write));
                    check("s_pwdata", 64'(bus.s_pwdata), 64'(e.wdata));
                    check("s_pstrb", 64'(bus.s_pstrb), 64'(e.strb));
                end
            end
            if (bus.pready) begin
                if (sb.size() == 0) check("spurious_pready", 64'(bus.pready), 64'd0);
                else begin
                    e = sb.pop_front();
                    check("prdata", 64'(bus.prdata), 64'(e.prdata));
                    check("pslverr", 64'(bus.pslverr), 64'(e.pslverr));
                    check("latency", 64'(cyc - e.start), 64'(e.lat));
                    check("resp_downstream_idle", 64'({bus.s_psel, bus.s_penable}), 64'd0);
                end
            end
        end
    end

    task automatic xfer(input logic [31:0] addr, input logic write, input logic [31:0] wdata,
                        input logic [3:0] strb, input int wt, input logic [95:0] rdv,
                        input logic [2:0] errv, input int viol);
        exp_t e;
        int   k;
        @(negedge clk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = write;
        bus.paddr = addr; bus.pwdata = wdata; bus.pstrb = strb;
        bus.s_prdata = rdv; bus.s_pslverr = errv;
        cur_wait = wt;
        e = model(addr, write, wdata, strb, wt, rdv, errv);
        e.start = cyc;
        sb.push_back(e);
        k = 0;
        forever begin
            @(negedge clk);
            if (bus.pready) break;
            if (k >= 40) begin
                check("pready_wait_bound", 64'd0, 64'd1);
                sb.delete();
                break;
            end
            // Upstream misbehaviour while busy must not disturb the transfer in flight.
            case (viol)
                1:       begin bus.psel = 1'b0; bus.penable = 1'b0; end
                2:       begin bus.psel = 1'b1; bus.penable = 1'($urandom); bus.paddr = $urandom; end
                default: begin bus.psel = 1'b1; bus.penable = 1'b1; end
            endcase
            k++;
        end
        bus.psel = 1'b0; bus.penable = 1'b0;
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'(bus.pready) | 64'(bus.pslverr) | 64'(bus.prdata) | 64'(bus.s_psel) | 64'(bus.s_penable)
             | 64'(bus.s_pwrite) | 64'(bus.s_paddr) | 64'(bus.s_pstrb) | 64'(bus.s_pwdata);
    endfunction

    initial begin
        logic [95:0] rdv;
        logic [31:0] a;
        exp_t        e;
        rst = 1'b1;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = '0; bus.pwdata = '0; bus.pstrb = '0;
        bus.s_prdata = '0; bus.s_pslverr = '0;
        #1;
        check("reset_outputs", all_outputs(), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        rdv = {$urandom, 32'hDEAD_BEEF, $urandom};
        xfer(32'h0400_0004, 1'b0, 32'd0, 4'hF, 0, rdv, 3'b000, 0);
        xfer(32'h0000_0010, 1'b1, 32'h1234_5678, 4'b0011, 2, {$urandom, $urandom, $urandom}, 3'b000, 0);
        xfer(32'h0C00_0000, 1'b0, 32'd0, 4'hF, 0, {$urandom, $urandom, $urandom}, 3'b000, 0);
        xfer(32'h0000_0008, 1'b0, 32'd0, 4'hF, 20, {$urandom, $urandom, $urandom}, 3'b000, 0);
        rdv = {$urandom, $urandom, 32'hCAFE_0001};
        xfer(32'h0000_0000, 1'b0, 32'd0, 4'hF, int'(TIMEOUT) - 1, rdv, 3'b000, 0);
        xfer(32'h0800_0100, 1'b0, 32'd0, 4'hF, 1, {$urandom, $urandom, $urandom}, 3'b100, 0);

        // Reset pulsed during DACCESS: outputs clear at once and the pending response is dropped.
        @(negedge clk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 32'h0400_0020;
        cur_wait = 3;
        e = model(32'h0400_0020, 1'b0, bus.pwdata, bus.pstrb, 3, {$urandom, $urandom, $urandom}, 3'b000);
        e.start = cyc;
        sb.push_back(e);
        @(negedge clk); bus.penable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_daccess", 64'({bus.s_psel, bus.s_penable}), 64'({3'b010, 1'b1}));
        rst = 1'b1;
        #1;
        check("async_reset_outputs", all_outputs(), 64'd0);
        sb.delete();
        bus.psel = 1'b0; bus.penable = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        xfer(32'h0400_0004, 1'b0, 32'd0, 4'hF, 0, {$urandom, $urandom, $urandom}, 3'b000, 0);

        for (int n = 0; n < 200; n++) begin
            a = $urandom;
            a[SEL_LSB +: 2] = 2'($urandom_range(0, 3));
            xfer(a, 1'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, 6)),
                 {$urandom, $urandom, $urandom}, 3'($urandom), int'($urandom_range(0, 5)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
